// File: rtl/tmr_vote_monitor.sv
// TMR rejoin point: registered 2-of-3 vote plus domain disagreement monitor.
// Optional fault-injection ports on domain A: define TMR_VOTE_INJECT_EN.
module tmr_vote_monitor #(
    parameter int WIDTH       = 8,
    parameter int CNT_W       = 16,
    parameter int FAIL_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [WIDTH-1:0] inC,
`ifdef TMR_VOTE_INJECT_EN
    input  logic             inj_en,
    input  logic [WIDTH-1:0] inj_mask,
`endif
    input  logic             clr,
    output logic [WIDTH-1:0] out,
    output logic             mismatch,
    output logic [2:0]       err_dom,
    output logic             triple_err,
    output logic [2:0]       fail,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int CONS_W = $clog2(FAIL_THRESH + 1);
    localparam logic [CONS_W-1:0] THRESH = CONS_W'(FAIL_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] domA;
    logic [WIDTH-1:0] vote;
    logic eqAB, eqAC, eqBC;
    logic isClean, isTriple;
    logic [2:0] minority;
    logic [2:0][CONS_W-1:0] cons;
    logic [2:0][CONS_W-1:0] consNext;
    logic [2:0] failSet;

`ifdef TMR_VOTE_INJECT_EN
    assign domA = inj_en ? (inA ^ inj_mask) : inA;
`else
    assign domA = inA;
`endif

    // Classify the word agreement and form the bitwise majority.
    always_comb begin
        eqAB     = (domA == inB);
        eqAC     = (domA == inC);
        eqBC     = (inB == inC);
        isClean  = eqAB & eqAC;
        isTriple = ~eqAB & ~eqAC & ~eqBC;
        minority = {eqAB & ~eqAC, eqAC & ~eqAB, eqBC & ~eqAB};
        vote     = (domA & inB) | (domA & inC) | (inB & inC);
    end

    // Next value of each per-domain consecutive-minority counter.
    always_comb begin
        consNext = cons;
        failSet  = 3'b000;
        for (int d = 0; d < 3; d++) begin
            if (isTriple) begin
                consNext[d] = cons[d];
            end else if (minority[d]) begin
                if (cons[d] != THRESH) begin
                    consNext[d] = cons[d] + CONS_W'(1);
                end
            end else begin
                consNext[d] = '0;
            end
            failSet[d] = (consNext[d] == THRESH);
        end
    end

    // Registered vote and per-cycle classification flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            out        <= '0;
            mismatch   <= 1'b0;
            err_dom    <= 3'b000;
            triple_err <= 1'b0;
        end else begin
            out        <= vote;
            mismatch   <= ~isClean;
            err_dom    <= minority;
            triple_err <= isTriple;
        end
    end

    // Persistent-fault tracking: consecutive counters and sticky flags.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cons <= '0;
            fail <= 3'b000;
        end else begin
            cons <= consNext;
            fail <= fail | failSet;
        end
    end

    // Saturating count of disagreement cycles.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            err_cnt <= '0;
        end else if (!isClean && err_cnt != CNT_MAX) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Bench for tmr_vote_monitor: vector table plus corner sequences.
// Expected values are hand-derived and queued when stimulus is driven.
module tb_tmr_vote_monitor;

    typedef struct {
        logic       rst;
        logic       clr;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic       inj;
        logic [7:0] mask;
        logic [7:0] eOut;
        logic       eMis;
        logic [2:0] eDom;
        logic       eTri;
        logic [2:0] eFail;
        logic [3:0] eCnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [7:0] inA = '0;
    logic [7:0] inB = '0;
    logic [7:0] inC = '0;
    logic       injEn = 1'b0;
    logic [7:0] injMask = '0;
    logic [7:0] out;
    logic       mismatch;
    logic [2:0] errDom;
    logic       tripleErr;
    logic [2:0] fail;
    logic [3:0] errCnt;

    int nCompared = 0;
    int nMismatched = 0;

    vec_t vecs[$];
    vec_t expQ[$];

    always #5 clk = ~clk;

    tmr_vote_monitor #(
        .WIDTH(8),
        .CNT_W(4),
        .FAIL_THRESH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .inA(inA),
        .inB(inB),
        .inC(inC),
`ifdef TMR_VOTE_INJECT_EN
        .inj_en(injEn),
        .inj_mask(injMask),
`endif
        .clr(clr),
        .out(out),
        .mismatch(mismatch),
        .err_dom(errDom),
        .triple_err(tripleErr),
        .fail(fail),
        .err_cnt(errCnt)
    );

    function automatic vec_t mk(
        input logic r, input logic cl,
        input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
        input logic [7:0] eOut, input logic eMis, input logic [2:0] eDom,
        input logic eTri, input logic [2:0] eFail, input logic [3:0] eCnt
    );
        vec_t v;
        v.rst = r;     v.clr = cl;
        v.a = a;       v.b = b;       v.c = c;
        v.inj = 1'b0;  v.mask = 8'h00;
        v.eOut = eOut; v.eMis = eMis; v.eDom = eDom;
        v.eTri = eTri; v.eFail = eFail; v.eCnt = eCnt;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s step %0d: got %0h expected %0h",
                     name, idx, act, exp);
        end
    endtask

    int stepNo = 0;

    task automatic drive(input vec_t v);
        vec_t e;
        rst     = v.rst;
        clr     = v.clr;
        inA     = v.a;
        inB     = v.b;
        inC     = v.c;
        injEn   = v.inj;
        injMask = v.mask;
        expQ.push_back(v);
        @(posedge clk);
        #1;
        e = expQ.pop_front();
        chk("out", stepNo, 32'(out), 32'(e.eOut));
        chk("mismatch", stepNo, 32'(mismatch), 32'(e.eMis));
        chk("err_dom", stepNo, 32'(errDom), 32'(e.eDom));
        chk("triple_err", stepNo, 32'(tripleErr), 32'(e.eTri));
        chk("fail", stepNo, 32'(fail), 32'(e.eFail));
        chk("err_cnt", stepNo, 32'(errCnt), 32'(e.eCnt));
        stepNo++;
    endtask

    initial begin
        vec_t v;

        // reset
        for (int i = 0; i < 2; i++)
            vecs.push_back(mk(1, 0, 8'h00, 8'h00, 8'h00,
                              8'h00, 0, 3'b000, 0, 3'b000, 4'd0));
        // clean
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(0, 0, 8'h5A, 8'h5A, 8'h5A,
                              8'h5A, 0, 3'b000, 0, 3'b000, 4'd0));
        // single upset on B, then clean
        vecs.push_back(mk(0, 0, 8'h5A, 8'h5B, 8'h5A,
                          8'h5A, 1, 3'b010, 0, 3'b000, 4'd1));
        vecs.push_back(mk(0, 0, 8'h5A, 8'h5A, 8'h5A,
                          8'h5A, 0, 3'b000, 0, 3'b000, 4'd1));
        // clear, then persistent fault on C
        vecs.push_back(mk(0, 1, 8'h00, 8'h00, 8'h00,
                          8'h00, 0, 3'b000, 0, 3'b000, 4'd0));
        for (int i = 1; i <= 4; i++)
            vecs.push_back(mk(0, 0, 8'h00, 8'h00, 8'hFF,
                              8'h00, 1, 3'b100, 0,
                              (i == 4) ? 3'b100 : 3'b000, 4'(i)));
        // triple error
        vecs.push_back(mk(0, 0, 8'h01, 8'h02, 8'h04,
                          8'h00, 1, 3'b000, 1, 3'b100, 4'd5));
        // clear, A minority x3, clean, A minority x3 total
        vecs.push_back(mk(0, 1, 8'h00, 8'h00, 8'h00,
                          8'h00, 0, 3'b000, 0, 3'b000, 4'd0));
        for (int i = 1; i <= 3; i++)
            vecs.push_back(mk(0, 0, 8'hFF, 8'h00, 8'h00,
                              8'h00, 1, 3'b001, 0, 3'b000, 4'(i)));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00,
                          8'h00, 0, 3'b000, 0, 3'b000, 4'd3));
        for (int i = 4; i <= 6; i++)
            vecs.push_back(mk(0, 0, 8'hFF, 8'h00, 8'h00,
                              8'h00, 1, 3'b001, 0, 3'b000, 4'(i)));
        // triple holds consA at 3; next minority reaches threshold
        vecs.push_back(mk(0, 0, 8'h01, 8'h02, 8'h04,
                          8'h00, 1, 3'b000, 1, 3'b000, 4'd7));
        vecs.push_back(mk(0, 0, 8'hFF, 8'h00, 8'h00,
                          8'h00, 1, 3'b001, 0, 3'b001, 4'd8));
        // sticky after recovery
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00,
                          8'h00, 0, 3'b000, 0, 3'b001, 4'd8));
        // 20 B-minority cycles: counter saturates at 15
        for (int k = 1; k <= 20; k++)
            vecs.push_back(mk(0, 0, 8'h33, 8'h00, 8'h33,
                              8'h33, 1, 3'b010, 0,
                              (k >= 4) ? 3'b011 : 3'b001,
                              4'((8 + k > 15) ? 15 : 8 + k)));

        for (int i = 0; i < vecs.size(); i++)
            drive(vecs[i]);

        // clr with mismatch, held three cycles
        for (int i = 0; i < 3; i++)
            drive(mk(0, 1, 8'h33, 8'h00, 8'h33,
                     8'h33, 1, 3'b010, 0, 3'b000, 4'd0));
        // counting resumes from zero; fail needs a fresh run
        for (int i = 1; i <= 3; i++)
            drive(mk(0, 0, 8'h33, 8'h00, 8'h33,
                     8'h33, 1, 3'b010, 0, 3'b000, 4'(i)));
        // rst mid-burst, with clr also high
        drive(mk(1, 1, 8'h33, 8'h00, 8'h33,
                 8'h00, 0, 3'b000, 0, 3'b000, 4'd0));
        drive(mk(0, 0, 8'h33, 8'h00, 8'h33,
                 8'h33, 1, 3'b010, 0, 3'b000, 4'd1));
        // triple with a nontrivial per-bit vote
        drive(mk(0, 0, 8'hF0, 8'hCC, 8'hAA,
                 8'hE8, 1, 3'b000, 1, 3'b000, 4'd2));
`ifdef TMR_VOTE_INJECT_EN
        v = mk(0, 0, 8'h00, 8'h00, 8'h00,
               8'h00, 1, 3'b001, 0, 3'b000, 4'd3);
        v.inj = 1'b1;
        v.mask = 8'h80;
        drive(v);
`else
        v = mk(0, 0, 8'h00, 8'h00, 8'h00,
               8'h00, 0, 3'b000, 0, 3'b000, 4'd2);
        drive(v);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/tmr_vote_monitor.md
Name: tmr_vote_monitor

Overview:
- Downstream consumer of triplicated logic: takes the three domain copies (inA/inB/inC), produces a registered bitwise 2-of-3 majority word, and monitors domain disagreement.
- Flags single-domain upsets, detects persistent faults per domain (sticky fail flag), and keeps a saturating upset count for slow-control readout.
- Sits at the boundary where triplicated logic rejoins non-triplicated logic.

Parameters:
- WIDTH, 8, data width of each domain copy and of the voted output
- CNT_W, 16, width of the saturating error counter
- FAIL_THRESH, 4, consecutive minority cycles before a domain is declared failed; legal range 1..255

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- inA  input  WIDTH  domain A copy
- inB  input  WIDTH  domain B copy
- inC  input  WIDTH  domain C copy
- clr  input  1  synchronous clear of err_cnt and fail; single-cycle pulse
- out  output  WIDTH  registered bitwise majority of inA/inB/inC
- mismatch  output  1  registered; 1 if any two copies differed in the previous cycle
- err_dom  output  3  registered one-hot minority domain {C,B,A} from the previous cycle; 000 if none or unresolvable
- triple_err  output  1  registered; all three copies pairwise different in the previous cycle
- fail  output  3  sticky per-domain persistent-fault flags {C,B,A}
- err_cnt  output  CNT_W  saturating count of cycles with mismatch=1

Behaviour:
- Reset: clk and rst are the only clock and reset. rst is sampled on the rising edge of clk. All outputs and internal counters go to 0. rst has priority over clr and over all data.
- Latency: all outputs are registered. Inputs sampled at edge N appear at the outputs after edge N, i.e. one cycle of latency.
- Voting: out[i] = (A[i]&B[i]) | (A[i]&C[i]) | (B[i]&C[i]), computed per bit. Vote is always produced, including when triple_err=1.
- Word classification each cycle:
  - A==B==C: CLEAN. err_dom=000, mismatch=0.
  - A==B!=C: minority C, err_dom=100.
  - A==C!=B: minority B, err_dom=010.
  - B==C!=A: minority A, err_dom=001.
  - All pairwise different: TRIPLE. triple_err=1, err_dom=000.
  - mismatch=1 for any class other than CLEAN.
- Per-domain consecutive counter cons[d], width sized to hold FAIL_THRESH:
  - d is minority: increment, saturating at FAIL_THRESH.
  - Class is CLEAN or another domain is minority: reset to 0.
  - TRIPLE: hold.
- fail[d]:
  - Sets on the edge where cons[d] transitions to FAIL_THRESH.
  - Remains 1 until clr or rst, even if the domain recovers.
- err_cnt:
  - +1 on each mismatch cycle.
  - Saturates at 2^CNT_W-1; no wrap-around.
- clr:
  - Zeroes err_cnt, fail, and all cons[d] on the next edge.
  - clr in the same cycle as a mismatch: clr wins; err_cnt=0, fail=000, cons=0.
  - The mismatch/err_dom/triple_err registers still reflect that cycle's classification; clr does not clear them.
- clr held high for multiple cycles: counts and flags stay 0 for its whole duration.
- rst asserted mid-burst of errors: all state is cleared, and counting restarts from 0 after rst deasserts.

Optional Feature:
- Macro TMR_VOTE_INJECT_EN.
- Defined:
  - Adds ports inj_en (input, 1) and inj_mask (input, WIDTH).
  - When inj_en=1, domain A is replaced by inA ^ inj_mask before voting and classification.
  - Used for in-system testing of the monitor.
- Undefined:
  - Ports are absent.
  - Domain A is used unmodified.
  - No extra logic is present.

Test Plan:
- Reset/clean: rst=1 for 2 cycles, then inA=inB=inC=8'h5A for 10 cycles -> out=8'h5A one cycle later; mismatch=0, err_dom=000, err_cnt=0, fail=000.
- Single upset: inB=8'h5B for 1 cycle, others 8'h5A -> next cycle out=8'h5A, mismatch=1, err_dom=010, err_cnt=1; following cycle mismatch=0; fail=000.
- Persistent fault: inC=8'hFF for 4 consecutive cycles, A=B=8'h00 (FAIL_THRESH=4) -> fail=100 after the 4th edge; err_cnt=4; 3 consecutive then 1 clean then 1 more -> fail stays 000.
- Triple error: A=8'h01, B=8'h02, C=8'h04 -> out=8'h00, triple_err=1, err_dom=000, cons counters held, err_cnt+1.
- Saturation and clear: CNT_W=4, drive 20 mismatch cycles -> err_cnt=15; assert clr together with a mismatch -> err_cnt=0, fail=000, mismatch=1 for that cycle.
- Inject (TMR_VOTE_INJECT_EN): all inputs 8'h00, inj_en=1, inj_mask=8'h80 -> out=8'h00, err_dom=001, mismatch=1.
